// File: rtl/fp_pkg.sv
// Shared constants, state encoding and field helpers for the single-precision
// add/subtract sequencer.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MAN_HI   = 22;
  localparam int MAN_LO   = 0;

  function automatic logic is_special(input logic [31:0] x);
    return (x[EXP_HI:EXP_LO] == 8'hFF);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[EXP_HI:EXP_LO] == 8'hFF) && (x[MAN_HI:MAN_LO] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_add_seq_norm.sv
// Leading-one normalizer for the 25-bit mantissa sum: returns the normalized
// stored mantissa, the exponent correction and a zero indication.
module fp_norm25 (
  input  logic [24:0] sum,
  output logic [22:0] man,
  output logic [5:0]  shift,
  output logic        zero
);

  logic [4:0]  lz_s;
  logic        found_s;
  logic [22:0] shifted_s;

  // Priority search for the leading one below bit 23, then select the shift.
  always_comb begin
    man       = 23'd0;
    shift     = 6'd0;
    zero      = (sum == 25'd0);
    lz_s      = 5'd0;
    found_s   = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!found_s && sum[i]) begin
        lz_s    = 5'(23 - i);
        found_s = 1'b1;
      end
    end
    // the leading one lands on bit 23 and falls off: it is the hidden bit
    shifted_s = sum[22:0] << lz_s;
    if (sum[24]) begin
      man   = sum[23:1];
      shift = 6'h3F;
    end else if (sum[23]) begin
      man   = sum[22:0];
      shift = 6'd0;
    end else if (found_s) begin
      man   = shifted_s;
      shift = {1'b0, lz_s};
    end else begin
      man   = 23'd0;
      shift = 6'd0;
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer with
// valid/ready handshakes, truncating rounding and denormal flush-to-zero.
module fp_add_seq #(
  parameter int          MAN_W = 23,
  parameter int          EXP_W = 8,
  parameter logic [31:0] QNAN  = fp_pkg::QNAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  fp_pkg::state_e     state_r;
  logic [31:0]        a_r;
  logic [30:0]        b_r;
  logic               sb_r;
  logic               sign_l_r;
  logic               same_r;
  logic               both_neg_r;
  logic [EXP_W-1:0]   exp_l_r;
  logic [MAN_W:0]     m_l_r;
  logic [MAN_W:0]     m_s_r;
  logic [MAN_W+1:0]   sum_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        result_r;
  logic [2:0]         flags_r;

  logic               special_s;
  logic [31:0]        spec_res_s;
  logic [2:0]         spec_flags_s;
  logic [EXP_W-1:0]   ea_s, eb_s, d_s, exp_big_s;
  logic [MAN_W:0]     ma_s, mb_s, m_big_s, m_sh_s;
  logic               a_big_s;
  logic [MAN_W-1:0]   norm_man_s;
  logic [5:0]         norm_shift_s;
  logic               norm_zero_s;
  logic signed [9:0]  exp_new_s;
  logic [31:0]        norm_res_s;
  logic [2:0]         norm_flags_s;

  // NaN / infinity resolution on the raw input operands at accept time.
  always_comb begin
    special_s    = fp_pkg::is_special(a) | fp_pkg::is_special(b);
    spec_res_s   = 32'd0;
    spec_flags_s = 3'b000;
    if (fp_pkg::is_nan(a) || fp_pkg::is_nan(b)) begin
      spec_res_s   = QNAN;
      spec_flags_s = 3'b001;
    end else if (fp_pkg::is_special(a) && fp_pkg::is_special(b) && (a[31] != (b[31] ^ op_sub))) begin
      spec_res_s   = QNAN;
      spec_flags_s = 3'b001;
    end else if (fp_pkg::is_special(a)) begin
      spec_res_s   = {a[31], 8'hFF, 23'd0};
      spec_flags_s = 3'b000;
    end else if (fp_pkg::is_special(b)) begin
      spec_res_s   = {b[31] ^ op_sub, 8'hFF, 23'd0};
      spec_flags_s = 3'b000;
    end else begin
      spec_res_s   = 32'd0;
      spec_flags_s = 3'b000;
    end
  end

  // Flush denormals, order operands by magnitude and align the smaller one.
  always_comb begin
    ea_s = a_r[30:23];
    eb_s = b_r[30:23];
    ma_s = (ea_s == 8'd0) ? 24'd0 : {1'b1, a_r[22:0]};
    mb_s = (eb_s == 8'd0) ? 24'd0 : {1'b1, b_r[22:0]};
    a_big_s = ({ea_s, ma_s[22:0]} >= {eb_s, mb_s[22:0]});
    if (a_big_s) begin
      exp_big_s = ea_s;
      m_big_s   = ma_s;
      d_s       = ea_s - eb_s;
      m_sh_s    = (d_s >= 8'd25) ? 24'd0 : (mb_s >> d_s);
    end else begin
      exp_big_s = eb_s;
      m_big_s   = mb_s;
      d_s       = eb_s - ea_s;
      m_sh_s    = (d_s >= 8'd25) ? 24'd0 : (ma_s >> d_s);
    end
  end

  fp_norm25 u_norm (
    .sum   (sum_r),
    .man   (norm_man_s),
    .shift (norm_shift_s),
    .zero  (norm_zero_s)
  );

  // Apply the normalizer shift to the exponent and pack with range checks.
  always_comb begin
    exp_new_s = $signed({2'b00, exp_l_r}) - $signed({{4{norm_shift_s[5]}}, norm_shift_s});
    if (norm_zero_s) begin
      norm_res_s   = {both_neg_r, 31'd0};
      norm_flags_s = 3'b000;
    end else if (exp_new_s >= 10'sd255) begin
      norm_res_s   = {sign_l_r, 8'hFF, 23'd0};
      norm_flags_s = 3'b100;
    end else if (exp_new_s <= 10'sd0) begin
      norm_res_s   = {sign_l_r, 31'd0};
      norm_flags_s = 3'b010;
    end else begin
      norm_res_s   = {sign_l_r, exp_new_s[7:0], norm_man_s};
      norm_flags_s = 3'b000;
    end
  end

  // Sequencer: one state per datapath step, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= fp_pkg::ST_IDLE;
      a_r         <= 32'd0;
      b_r         <= 31'd0;
      sb_r        <= 1'b0;
      sign_l_r    <= 1'b0;
      same_r      <= 1'b0;
      both_neg_r  <= 1'b0;
      exp_l_r     <= 8'd0;
      m_l_r       <= 24'd0;
      m_s_r       <= 24'd0;
      sum_r       <= 25'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
      flags_r     <= 3'b000;
    end else begin
      case (state_r)
        fp_pkg::ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b[30:0];
            sb_r       <= b[31] ^ op_sub;
            in_ready_r <= 1'b0;
            if (special_s) begin
              result_r <= spec_res_s;
              flags_r  <= spec_flags_s;
              state_r  <= fp_pkg::ST_DONE;
            end else begin
              state_r  <= fp_pkg::ST_ALIGN;
            end
          end
        end
        fp_pkg::ST_ALIGN: begin
          sign_l_r   <= a_big_s ? a_r[31] : sb_r;
          same_r     <= (a_r[31] == sb_r);
          both_neg_r <= a_r[31] & sb_r;
          exp_l_r    <= exp_big_s;
          m_l_r      <= m_big_s;
          m_s_r      <= m_sh_s;
          state_r    <= fp_pkg::ST_ADD;
        end
        fp_pkg::ST_ADD: begin
          sum_r   <= same_r ? ({1'b0, m_l_r} + {1'b0, m_s_r}) : ({1'b0, m_l_r} - {1'b0, m_s_r});
          state_r <= fp_pkg::ST_NORM;
        end
        fp_pkg::ST_NORM: begin
          result_r <= norm_res_s;
          flags_r  <= norm_flags_s;
          state_r  <= fp_pkg::ST_DONE;
        end
        fp_pkg::ST_DONE: begin
          // out_valid rises one cycle after entering DONE
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= fp_pkg::ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= fp_pkg::ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: expected results are queued at accept
// and compared when the sequencer presents its result.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  int checks   = 0;
  int failures = 0;
  logic [34:0] exp_q[$];

  fp_add_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Present one operand pair (bounded wait for in_ready) and queue its expectation.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                      input logic [31:0] er, input logic [2:0] ef);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tb_; op_sub = top; in_valid = 1'b1;
    exp_q.push_back({ef, er});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop(output logic [31:0] er, output logic [2:0] ef);
    logic [34:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
    er = e[31:0];
    ef = e[34:32];
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Full transaction: send, wait for result, capture it, pop expectation, hand off.
  task automatic xact(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                      input logic [31:0] er, input logic [2:0] ef, output int lat,
                      output logic [31:0] got_r, output logic [2:0] got_f,
                      output logic [31:0] want_r, output logic [2:0] want_f);
    send(ta, tb_, top, er, ef);
    wait_out(lat);
    got_r = result;
    got_f = flags;
    pop(want_r, want_f);
    handoff();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = 32'd0; b = 32'd0; out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || flags !== 3'd0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h flags=%b want 1 0 00000000 000",
               in_ready, out_valid, result, flags);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Vector table: a, b, op_sub, expected result, expected flags, expected latency.
  task automatic test_vectors();
    logic [31:0] va[12], vb[12], vr[12];
    logic        vo[12];
    logic [2:0]  vf[12];
    int          vl[12];
    int          lat;
    logic [31:0] gr, wr;
    logic [2:0]  gf, wf;
    va = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF,
           32'h7F800000, 32'h7FC00001, 32'h3F800000, 32'h00800000, 32'h80000000, 32'h3FC00000};
    vb = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h30800000, 32'h3F800000, 32'h7F7FFFFF,
           32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h00800001, 32'h80000000, 32'h40100000};
    vo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vr = '{32'h40000000, 32'h40000000, 32'h00000000, 32'h3F800000, 32'h34000000, 32'h7F800000,
           32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000, 32'h40700000};
    vf = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
           3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b000};
    vl = '{4, 4, 4, 4, 4, 4, 1, 1, 1, 4, 4, 4};
    for (int i = 0; i < 12; i++) begin
      xact(va[i], vb[i], vo[i], vr[i], vf[i], lat, gr, gf, wr, wf);
      checks++;
      if (lat != vl[i]) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d want %0d", i, lat, vl[i]);
      end
      checks++;
      if (gr !== wr || gf !== wf) begin
        failures++;
        $display("FAIL result[%0d]: got %h/%b want %h/%b", i, gr, gf, wr, wf);
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL handoff[%0d]: out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] wr;
    logic [2:0]  wf;
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    wait_out(lat);
    pop(wr, wf);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== wr || flags !== wf) begin
        failures++;
        $display("FAIL hold[%0d]: ov=%b ir=%b res=%h fl=%b want 1 0 %h %b",
                 i, out_valid, in_ready, result, flags, wr, wf);
      end
      @(posedge clk); #1;
    end
    handoff();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  // Abort in ALIGN, ADD and NORM; the following operation must be clean.
  task automatic test_reset_midop();
    int          lat;
    logic [31:0] gr, wr;
    logic [2:0]  gf, wf;
    for (int depth = 0; depth < 3; depth++) begin
      send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
      for (int k = 0; k < depth; k++) begin
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
        failures++;
        $display("FAIL abort[%0d]: out_valid=%b in_ready=%b result=%h want 0 1 00000000",
                 depth, out_valid, in_ready, result);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale[%0d]: out_valid=%b want 0", depth, out_valid);
      end
      xact(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, lat, gr, gf, wr, wf);
      checks++;
      if (gr !== wr || gf !== wf || lat != 4) begin
        failures++;
        $display("FAIL after_abort[%0d]: got %h/%b lat %0d want %h/%b lat 4", depth, gr, gf, lat, wr, wf);
      end
    end
  endtask

  // Consumer always ready: consecutive operations must not disturb each other.
  task automatic test_back_to_back();
    int          lat;
    logic [31:0] wr;
    logic [2:0]  wf;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'h40400000 + (i << 20), 32'h3F800000, 1'b0,
           (i == 0) ? 32'h40800000 : ((i == 1) ? 32'h40880000 : 32'h40900000), 3'b000);
      wait_out(lat);
      pop(wr, wf);
      checks++;
      if (result !== wr || flags !== wf || lat != 4) begin
        failures++;
        $display("FAIL b2b[%0d]: got %h/%b lat %0d want %h/%b lat 4", i, result, flags, lat, wr, wf);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
